reg_alu_core: RTL and testbench
===============================

// Module: reg_alu_core
// PURPOSE
//  16-bit datapath slice: an 8 x 16 register file with two combinational read ports and one
//  synchronous write port, plus an execution unit. The execution unit is an add/sub/and/or ALU,
//  a barrel shifter (left, logical right, arithmetic right) and a signed set-less-than.
//  Each cycle it writes either external data or the execution result back into the file.
//  It is the execute/writeback core of the teaching CPU.
// PARAMETERS
//  none; widths fixed: DATA_W=16, NREGS=8, ADDR_W=3, SHAMT_W=4.
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high; clears register file
//  slt_sel      in   1   1: result = signed(A) < signed(B) ? 1 : 0 (highest priority)
//  sel          in   1   write-data select: 0 = d_in, 1 = execution result
//  main_sel     in   1   0 = ALU result, 1 = shifter result (when slt_sel=0)
//  sft_sel      in   1   shifter direction: 0 = left, 1 = right
//  ryt_sft_sel  in   1   right-shift kind: 0 = logical, 1 = arithmetic (ignored if sft_sel=0)
//  wr           in   1   write enable
//  op           in   2   ALU op: 00 add, 01 sub (A-B), 10 and, 11 or
//  sft_op       in   4   shift amount 0..15, applied to operand A
//  rd_addr_a    in   3   read port A address (operand A)
//  rd_addr_b    in   3   read port B address (operand B)
//  wr_addr      in   3   write address
//  d_in         in   16  external write data
//  d_out_a      out  16  regs[rd_addr_a], combinational
//  d_out_b      out  16  regs[rd_addr_b], combinational
//  cout         out  1   ALU carry out, combinational
// BEHAVIOUR
//  - Sync reset: on posedge clk with reset=1, all 8 regs <= 0; reset has priority over wr.
//  - Outputs after reset: d_out_a = d_out_b = 0. cout follows the ALU inputs.
//  - A = regs[rd_addr_a], B = regs[rd_addr_b]. Reads are asynchronous.
//  - Read of the register being written in the same cycle returns the OLD value.
//    The new value is visible after the edge; no bypass.
//  - Result priority: slt_sel=1 -> {15'b0, $signed(A)<$signed(B)}.
//    Otherwise main_sel=1 -> shifter. Otherwise -> ALU.
//  - ALU: add = A+B, cout = carry bit 16. sub = A+~B+1, cout = carry bit 16 (1 = no borrow).
//    and/or: bitwise, cout = 0. Results wrap mod 2^16.
//  - Shifter: left = A << sft_op. Logical right = A >> sft_op (zero fill).
//    Arithmetic right = sign-fill with A[15]. sft_op=0 passes A unchanged.
//  - Write: on posedge clk, if !reset && wr: regs[wr_addr] <= sel ? result : d_in.
//    With wr=0, no register changes.
//  - Latency: result is combinational; writeback takes 1 cycle. All regs incl. r0 are writable.
//  - X on unused address fields is legal; it must not corrupt state when wr=0 or sel=0.
// STRUCTURE
//  - Shared package: ALU op codes (OP_ADD=2'b00, OP_SUB=01, OP_AND=10, OP_OR=11).
//    Also holds DATA_W, ADDR_W, SHAMT_W.
//  - One sub-module: reg_alu_shifter (16-bit barrel shifter: A, shamt, dir, arith -> Y).
//  - Register file, ALU, slt and result muxes stay inline.
// TESTING
//  - Reset, then read all 8 regs -> 0.
//    Write 1023 -> r0 and 907 -> r1 (sel=0, wr=1) -> d_out_a(r0)=1023, d_out_b(r1)=907 next cycle.
//  - r0=1023, r1=907: add (sel=1, main_sel=0, op=00) into r2 -> r2=1930, cout=0.
//    With r3=16'hFFFF, r4=1: add -> 0, cout=1. sub(1-2) -> 16'hFFFF, cout=0.
//  - A=16'h8001 (32769): shift left by 1 -> 16'h0002. Logical right by 4 -> 16'h0800.
//    Arithmetic right by 4 -> 16'hF800. Shift by 0 -> 16'h8001.
//  - slt: A=101, B=678 -> 1. A=41245 (-24291), B=37119 (-28417) -> 0.
//    A=B -> 0. A=-1, B=0 -> 1.
//  - wr=0 with sel/op toggling -> no register changes.
//    Write and read of the same reg in one cycle -> old value, then new value after the edge.
//  - reset=1 together with wr=1 -> all regs 0; the write is dropped.

Source files
------------

// File: rtl/reg_alu_core_pkg.sv
// Shared widths and ALU opcodes for the reg_alu_core execute/writeback slice.
package reg_alu_core_pkg;

  localparam int DATA_W  = 16;
  localparam int NREGS   = 8;
  localparam int ADDR_W  = 3;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  // Mirror a data word end-for-end; lets one right-shift network serve left shifts too.
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/reg_alu_shifter.sv
// 16-bit logarithmic barrel shifter: left, logical right, arithmetic right.
// Left shifts reverse the operand, shift right with zero fill, and reverse back.
module reg_alu_shifter
  import reg_alu_core_pkg::*;
(
  input  logic [DATA_W-1:0]  a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               dir_i,    // 0 = left, 1 = right
  input  logic               arith_i,  // right shifts only: 1 = sign fill
  output logic [DATA_W-1:0]  y_o
);

  logic              fill;
  logic [DATA_W-1:0] stg [SHAMT_W+1];

  // Sign fill applies only to arithmetic right shifts; everything else fills with zero.
  assign fill   = dir_i & arith_i & a_i[DATA_W-1];
  assign stg[0] = dir_i ? a_i : bit_rev(a_i);

  // Stage i shifts right by 2**i when the matching shift-amount bit is set.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stg[i+1] = shamt_i[i] ? {{S{fill}}, stg[i][DATA_W-1:S]} : stg[i];
  end

  assign y_o = dir_i ? stg[SHAMT_W] : bit_rev(stg[SHAMT_W]);

endmodule

// File: rtl/reg_alu_core.sv
// Execute/writeback core: 8x16 register file (2 async reads, 1 sync write),
// add/sub/and/or ALU, barrel shifter and signed set-less-than.
module reg_alu_core
  import reg_alu_core_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               slt_sel,
  input  logic               sel,
  input  logic               main_sel,
  input  logic               sft_sel,
  input  logic               ryt_sft_sel,
  input  logic               wr,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] sft_op,
  input  logic [ADDR_W-1:0]  rd_addr_a,
  input  logic [ADDR_W-1:0]  rd_addr_b,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  d_in,
  output logic [DATA_W-1:0]  d_out_a,
  output logic [DATA_W-1:0]  d_out_b,
  output logic               cout
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_y, sft_y, result_d, wr_data_d;
  logic              is_sub;
  logic              slt;
  alu_op_e           op_e;

  // Asynchronous reads; a same-cycle write only shows up after the edge (no bypass).
  assign opa     = regs_q[rd_addr_a];
  assign opb     = regs_q[rd_addr_b];
  assign d_out_a = opa;
  assign d_out_b = opb;

  assign op_e   = alu_op_e'(op);
  assign is_sub = (op_e == OP_SUB);
  // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
  assign sum    = {1'b0, opa} + {1'b0, (is_sub ? ~opb : opb)} + {{DATA_W{1'b0}}, is_sub};
  assign slt    = $signed(opa) < $signed(opb);

  reg_alu_shifter u_shifter (
    .a_i     (opa),
    .shamt_i (sft_op),
    .dir_i   (sft_sel),
    .arith_i (ryt_sft_sel),
    .y_o     (sft_y)
  );

  // ALU result and carry; logic ops report no carry.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_y = '0;
    cout  = 1'b0;
    case (op_e)
      OP_ADD, OP_SUB: begin
        alu_y = sum[DATA_W-1:0];
        cout  = sum[DATA_W];
      end
      OP_AND: alu_y = opa & opb;
      OP_OR:  alu_y = opa | opb;
    endcase
  end

  // Result priority: slt, then shifter, then ALU; then pick writeback source.
  always_comb begin
    result_d = alu_y;
    if (slt_sel)       result_d = {{(DATA_W-1){1'b0}}, slt};
    else if (main_sel) result_d = sft_y;
    wr_data_d = sel ? result_d : d_in;
  end

  // Register file write port; reset clears every entry and overrides a pending write.
  always_ff @(posedge clk) begin
    // NOTE: this file is small and must read zero after reset, so it is built from
    // flops with a clear rather than an uninitialised RAM macro.
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr) begin
      // NOTE: non-blocking so same-edge readers of regs_q always see the pre-edge value.
      regs_q[wr_addr] <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_reg_alu_core.sv
// Self-checking bench for reg_alu_core: directed cases plus random traffic,
// checked by a negedge monitor against an arithmetic reference model.
module tb_reg_alu_core;

  logic        clk = 1'b0;
  logic        reset, slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr;
  logic [1:0]  op;
  logic [3:0]  sft_op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in, d_out_a, d_out_b;
  logic        cout;

  reg_alu_core dut (
    .clk(clk), .reset(reset), .slt_sel(slt_sel), .sel(sel), .main_sel(main_sel),
    .sft_sel(sft_sel), .ryt_sft_sel(ryt_sft_sel), .wr(wr), .op(op), .sft_op(sft_op),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .d_in(d_in),
    .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, wr, sel, slt, mainsel, sft, ryt;
    logic [1:0]  op;
    logic [3:0]  sh;
    logic [2:0]  ra, rb, wa;
    logic [15:0] din;
  } stim_t;

  typedef struct {
    string       name;
    logic [15:0] ea, eb;
    logic        ec;
    bit          has_const;
    logic [15:0] ca, cb;
    logic        cc;
  } exp_t;

  exp_t sb[$];
  int   model[8];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input logic [32:0] got, input logic [32:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s: got {a,b,cout}=%h required %h", nm, got, want);
    else
      n_pass++;
  endtask

  // Reference model: behaviour written as plain integer arithmetic.
  function automatic int sx16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int ref_result(input stim_t s, input int a, input int b);
    if (s.slt) return (sx16(a) < sx16(b)) ? 1 : 0;
    if (s.mainsel) begin
      if (!s.sft) return (a << s.sh) % 65536;
      if (!s.ryt) return a >> s.sh;
      return (sx16(a) >>> s.sh) & 'hFFFF;
    end
    case (s.op)
      2'd0:    return (a + b) % 65536;
      2'd1:    return (a - b + 65536) % 65536;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic ref_cout(input logic [1:0] o, input int a, input int b);
    if (o == 2'd0) return (a + b) >= 65536;
    if (o == 2'd1) return a >= b;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.wr = 0; s.sel = 0; s.slt = 0; s.mainsel = 0; s.sft = 0; s.ryt = 0;
    s.op = 2'd0; s.sh = 4'd0; s.ra = 3'd0; s.rb = 3'd0; s.wa = 3'd0; s.din = 16'h0;
    return s;
  endfunction

  // Drive one cycle (entered at posedge+1), queue its expectation, advance the model.
  task automatic apply(input stim_t s, input string nm, input bit has_c,
                       input logic [15:0] ca, input logic [15:0] cb, input logic cc);
    exp_t e;
    int   a, b;
    reset = s.rst; wr = s.wr; sel = s.sel; slt_sel = s.slt; main_sel = s.mainsel;
    sft_sel = s.sft; ryt_sft_sel = s.ryt; op = s.op; sft_op = s.sh;
    rd_addr_a = s.ra; rd_addr_b = s.rb; wr_addr = s.wa; d_in = s.din;
    a = model[s.ra];
    b = model[s.rb];
    e.name = nm; e.ea = a[15:0]; e.eb = b[15:0]; e.ec = ref_cout(s.op, a, b);
    e.has_const = has_c; e.ca = ca; e.cb = cb; e.cc = cc;
    sb.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      for (int i = 0; i < 8; i++) model[i] = 0;
    end else if (s.wr) begin
      model[s.wa] = s.sel ? ref_result(s, a, b) : int'(s.din);
    end
    #1;
  endtask

  task automatic wr_ext(input logic [2:0] wa, input logic [15:0] d);
    stim_t s = idle();
    s.wr = 1; s.wa = wa; s.ra = wa; s.rb = wa; s.din = d;
    apply(s, "wr_ext", 0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic exec(input bit slt, input bit mainsel, input bit sft, input bit ryt,
                      input logic [1:0] o, input logic [3:0] sh,
                      input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa);
    stim_t s = idle();
    s.wr = 1; s.sel = 1; s.slt = slt; s.mainsel = mainsel; s.sft = sft; s.ryt = ryt;
    s.op = o; s.sh = sh; s.ra = ra; s.rb = rb; s.wa = wa;
    s.din = 16'hDEAD;
    apply(s, "exec", 0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] o,
                    input logic [15:0] ca, input logic [15:0] cb, input logic cc,
                    input string nm);
    stim_t s = idle();
    s.ra = ra; s.rb = rb; s.op = o;
    apply(s, nm, 1, ca, cb, cc);
  endtask

  // Monitor: outputs are combinational, so compare once per cycle at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ":model"}, {d_out_a, d_out_b, cout}, {e.ea, e.eb, e.ec});
      if (e.has_const)
        check({e.name, ":const"}, {d_out_a, d_out_b, cout}, {e.ca, e.cb, e.cc});
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 8; i++) model[i] = 0;
    s = idle();
    reset = 1; wr = 0; sel = 0; slt_sel = 0; main_sel = 0; sft_sel = 0; ryt_sft_sel = 0;
    op = 0; sft_op = 0; rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; d_in = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i), 2'd0, 16'h0, 16'h0, 1'b0, "reset_rd");

    // External writes
    wr_ext(3'd0, 16'd1023);
    wr_ext(3'd1, 16'd907);
    rd(3'd0, 3'd1, 2'd0, 16'd1023, 16'd907, 1'b0, "wr_ext_rd");

    // ALU add / carry / sub
    exec(0, 0, 0, 0, 2'd0, 4'd0, 3'd0, 3'd1, 3'd2);
    rd(3'd2, 3'd2, 2'd0, 16'd1930, 16'd1930, 1'b0, "add_1930");
    wr_ext(3'd3, 16'hFFFF);
    wr_ext(3'd4, 16'd1);
    rd(3'd3, 3'd4, 2'd0, 16'hFFFF, 16'd1, 1'b1, "add_cout1");
    exec(0, 0, 0, 0, 2'd0, 4'd0, 3'd3, 3'd4, 3'd5);
    rd(3'd5, 3'd5, 2'd3, 16'h0, 16'h0, 1'b0, "add_wrap");
    wr_ext(3'd6, 16'd2);
    rd(3'd4, 3'd6, 2'd1, 16'd1, 16'd2, 1'b0, "sub_borrow");
    exec(0, 0, 0, 0, 2'd1, 4'd0, 3'd4, 3'd6, 3'd7);
    rd(3'd7, 3'd7, 2'd2, 16'hFFFF, 16'hFFFF, 1'b0, "sub_1m2");

    // Shifter
    wr_ext(3'd0, 16'h8001);
    exec(0, 1, 0, 0, 2'd2, 4'd1, 3'd0, 3'd0, 3'd1);
    exec(0, 1, 1, 0, 2'd2, 4'd4, 3'd0, 3'd0, 3'd2);
    exec(0, 1, 1, 1, 2'd2, 4'd4, 3'd0, 3'd0, 3'd3);
    exec(0, 1, 1, 1, 2'd2, 4'd0, 3'd0, 3'd0, 3'd5);
    rd(3'd1, 3'd0, 2'd2, 16'h0002, 16'h8001, 1'b0, "shl1");
    rd(3'd2, 3'd3, 2'd2, 16'h0800, 16'hF800, 1'b0, "shr4_lsr_asr");
    rd(3'd5, 3'd5, 2'd3, 16'h8001, 16'h8001, 1'b0, "sh0");

    // Signed set-less-than
    wr_ext(3'd0, 16'd101);
    wr_ext(3'd1, 16'd678);
    exec(1, 0, 0, 0, 2'd0, 4'd0, 3'd0, 3'd1, 3'd2);
    rd(3'd2, 3'd2, 2'd2, 16'd1, 16'd1, 1'b0, "slt_pos");
    wr_ext(3'd3, 16'd41245);
    wr_ext(3'd4, 16'd37119);
    exec(1, 0, 0, 0, 2'd0, 4'd0, 3'd3, 3'd4, 3'd5);
    rd(3'd5, 3'd5, 2'd3, 16'h0, 16'h0, 1'b0, "slt_neg");
    exec(1, 1, 0, 0, 2'd0, 4'd3, 3'd0, 3'd0, 3'd6);
    rd(3'd6, 3'd6, 2'd3, 16'h0, 16'h0, 1'b0, "slt_eq");
    wr_ext(3'd7, 16'hFFFF);
    wr_ext(3'd4, 16'h0);
    exec(1, 0, 0, 0, 2'd0, 4'd0, 3'd7, 3'd4, 3'd3);
    rd(3'd3, 3'd3, 2'd3, 16'd1, 16'd1, 1'b0, "slt_m1_0");

    // wr=0 with everything else toggling, write address unknown
    for (int i = 0; i < 6; i++) begin
      s = idle();
      s.sel = 1'($urandom); s.slt = 1'($urandom); s.mainsel = 1'($urandom);
      s.sft = 1'($urandom); s.ryt = 1'($urandom); s.op = 2'($urandom); s.sh = 4'($urandom);
      s.ra = 3'($urandom); s.rb = 3'($urandom); s.wa = 'x; s.din = 16'($urandom);
      apply(s, "wr0_toggle", 0, 16'h0, 16'h0, 1'b0);
    end
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(i), 2'd2, 16'(model[i]), 16'(model[i]), 1'b0, "wr0_hold");

    // Same-cycle read of the register being written: old value, then new
    s = idle();
    s.wr = 1; s.wa = 3'd2; s.ra = 3'd2; s.rb = 3'd2; s.din = 16'h1234;
    apply(s, "rw_old", 1, 16'd1, 16'd1, 1'b0);
    rd(3'd2, 3'd2, 2'd3, 16'h1234, 16'h1234, 1'b0, "rw_new");

    // Reset wins over a simultaneous write
    s = idle();
    s.rst = 1; s.wr = 1; s.wa = 3'd3; s.ra = 3'd3; s.rb = 3'd3; s.din = 16'hBEEF;
    apply(s, "rst_wr", 0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(i), 2'd0, 16'h0, 16'h0, 1'b0, "rst_wr_rd");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      s.rst = ($urandom_range(0, 63) == 0); s.wr = 1'($urandom); s.sel = 1'($urandom);
      s.slt = ($urandom_range(0, 3) == 0); s.mainsel = 1'($urandom);
      s.sft = 1'($urandom); s.ryt = 1'($urandom); s.op = 2'($urandom); s.sh = 4'($urandom);
      s.ra = 3'($urandom); s.rb = 3'($urandom); s.wa = 3'($urandom); s.din = 16'($urandom);
      apply(s, "random", 0, 16'h0, 16'h0, 1'b0);
    end

    @(negedge clk);
    #1;
    check("sb_drain", 33'(sb.size()), 33'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
